// File: rtl/cga_tty.sv
// cga_tty -- text-mode terminal front end for the CGA video memory.
//
// Accepts a byte stream (valid/ready) and turns it into character/attribute
// writes on the second port of the video memory. Tracks the cursor and handles
// CR, LF, BS, form feed (screen clear), line wrap and scroll-up by copying rows.
//
// Optional feature macro: CGA_TTY_TAB_EN (when defined, 8'h09 advances the
// cursor to the next multiple of 8; otherwise 8'h09 is ignored).
//
// Ports:
//   clock        system clock (same domain as the video memory)
//   rst          asynchronous reset, active high; restarts a full screen clear
//   char_data    input byte, sampled only when char_valid && char_ready
//   char_valid   char_data valid
//   char_ready   high only in IDLE
//   mem_address  video memory byte address, (row*COLS+col)*2 (+1 for attribute)
//   mem_data     write data
//   mem_we       write strobe, one byte per asserted cycle
//   mem_q        read data, valid the cycle after mem_address is presented
//   cursor_x     current column
//   cursor_y     current row
//   busy         high in every state other than IDLE
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a byte, control codes handled in place
// PUT_CH  | character byte on the memory port
// PUT_AT  | attribute byte on the memory port, cursor advances on exit
// CLEAR   | filling the whole screen with blank/attribute pairs
// SC_RD   | scroll: source address (one row below) presented
// SC_WT   | scroll: read data arrives on mem_q
// SC_WR   | scroll: captured byte written one row up
// SC_FILL | scroll: blanking the last row

module cga_tty #(
    parameter int         COLS = 80,
    parameter int         ROWS = 25,
    parameter logic [7:0] ATTR = 8'h07
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [12:0] mem_address,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    input  logic [7:0]  mem_q,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, PUT_CH, PUT_AT, CLEAR, SC_RD, SC_WT, SC_WR, SC_FILL
    } state_t;

    localparam logic [12:0] ROW_BYTES  = 13'(COLS * 2);
    localparam logic [12:0] SCR_BYTES  = 13'(COLS * ROWS * 2);
    localparam logic [12:0] COPY_BYTES = 13'((ROWS - 1) * COLS * 2);
    localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);

    state_t      state_q;
    logic [12:0] idx_q;
    logic [6:0]  cursor_x_q;
    logic [4:0]  cursor_y_q;
    logic        mem_we_q;
    logic [12:0] mem_address_q;
    logic [7:0]  mem_data_q;
    logic        char_ready_q;
    logic        busy_q;

    logic [12:0] cell_idx_d;
    logic [12:0] cell_addr_d;

    assign cell_idx_d  = 13'(cursor_y_q) * 13'(COLS) + 13'(cursor_x_q);
    assign cell_addr_d = cell_idx_d << 1;

`ifdef CGA_TTY_TAB_EN
    logic [7:0] tab_x_d;
    assign tab_x_d = {1'b0, cursor_x_q & 7'h78} + 8'd8;
`endif

    assign char_ready  = char_ready_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_we      = mem_we_q;
    assign cursor_x    = cursor_x_q;
    assign cursor_y    = cursor_y_q;
    assign busy        = busy_q;

    // Outputs are registered together with the state, so they always describe
    // the cycle the FSM is currently in. CLEAR therefore issues its first write
    // one cycle after entry, and SC_WT->SC_WR captures mem_q straight into
    // mem_data_q without an extra holding register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q       <= CLEAR;
            idx_q         <= '0;
            cursor_x_q    <= '0;
            cursor_y_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            char_ready_q  <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (char_valid && char_ready_q) begin
                        if (char_data >= 8'h20) begin
                            state_q       <= PUT_CH;
                            mem_we_q      <= 1'b1;
                            mem_address_q <= cell_addr_d;
                            mem_data_q    <= char_data;
                            char_ready_q  <= 1'b0;
                            busy_q        <= 1'b1;
                        end else begin
                            case (char_data)
                                8'h0D: cursor_x_q <= '0;
                                8'h0A: begin
                                    if (cursor_y_q != LAST_ROW) begin
                                        cursor_y_q <= cursor_y_q + 5'd1;
                                    end else begin
                                        state_q       <= SC_RD;
                                        idx_q         <= '0;
                                        mem_address_q <= ROW_BYTES;
                                        cursor_x_q    <= '0;
                                        char_ready_q  <= 1'b0;
                                        busy_q        <= 1'b1;
                                    end
                                end
                                8'h08: begin
                                    if (cursor_x_q != 7'd0) begin
                                        cursor_x_q <= cursor_x_q - 7'd1;
                                    end
                                end
                                8'h0C: begin
                                    state_q      <= CLEAR;
                                    idx_q        <= '0;
                                    char_ready_q <= 1'b0;
                                    busy_q       <= 1'b1;
                                end
`ifdef CGA_TTY_TAB_EN
                                8'h09: begin
                                    if (tab_x_d >= 8'(COLS)) begin
                                        cursor_x_q <= '0;
                                        if (cursor_y_q != LAST_ROW) begin
                                            cursor_y_q <= cursor_y_q + 5'd1;
                                        end else begin
                                            state_q       <= SC_RD;
                                            idx_q         <= '0;
                                            mem_address_q <= ROW_BYTES;
                                            char_ready_q  <= 1'b0;
                                            busy_q        <= 1'b1;
                                        end
                                    end else begin
                                        cursor_x_q <= tab_x_d[6:0];
                                    end
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end

                PUT_CH: begin
                    state_q       <= PUT_AT;
                    mem_address_q <= mem_address_q + 13'd1;
                    mem_data_q    <= ATTR;
                end

                PUT_AT: begin
                    mem_we_q <= 1'b0;
                    if (cursor_x_q != LAST_COL) begin
                        cursor_x_q   <= cursor_x_q + 7'd1;
                        state_q      <= IDLE;
                        char_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else if (cursor_y_q != LAST_ROW) begin
                        cursor_x_q   <= '0;
                        cursor_y_q   <= cursor_y_q + 5'd1;
                        state_q      <= IDLE;
                        char_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        cursor_x_q    <= '0;
                        state_q       <= SC_RD;
                        idx_q         <= '0;
                        mem_address_q <= ROW_BYTES;
                    end
                end

                CLEAR: begin
                    if (idx_q == SCR_BYTES) begin
                        mem_we_q     <= 1'b0;
                        cursor_x_q   <= '0;
                        cursor_y_q   <= '0;
                        state_q      <= IDLE;
                        char_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        mem_we_q      <= 1'b1;
                        mem_address_q <= idx_q;
                        mem_data_q    <= idx_q[0] ? ATTR : 8'h20;
                        idx_q         <= idx_q + 13'd1;
                    end
                end

                SC_RD: state_q <= SC_WT;

                SC_WT: begin
                    state_q       <= SC_WR;
                    mem_we_q      <= 1'b1;
                    mem_address_q <= idx_q;
                    mem_data_q    <= mem_q;
                end

                SC_WR: begin
                    if (idx_q == COPY_BYTES - 13'd1) begin
                        // Last row starts on an even address, so the fill
                        // begins with a blank.
                        state_q       <= SC_FILL;
                        mem_address_q <= COPY_BYTES;
                        mem_data_q    <= 8'h20;
                    end else begin
                        state_q       <= SC_RD;
                        mem_we_q      <= 1'b0;
                        idx_q         <= idx_q + 13'd1;
                        mem_address_q <= idx_q + ROW_BYTES + 13'd1;
                    end
                end

                SC_FILL: begin
                    if (mem_address_q == SCR_BYTES - 13'd1) begin
                        mem_we_q     <= 1'b0;
                        cursor_x_q   <= '0;
                        cursor_y_q   <= LAST_ROW;
                        state_q      <= IDLE;
                        char_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        mem_address_q <= mem_address_q + 13'd1;
                        mem_data_q    <= mem_address_q[0] ? 8'h20 : ATTR;
                    end
                end

                default: begin
                    state_q      <= CLEAR;
                    idx_q        <= '0;
                    mem_we_q     <= 1'b0;
                    char_ready_q <= 1'b0;
                    busy_q       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cga_tty.sv
`timescale 1ns/1ps
module tb_cga_tty;

    localparam int         COLS = 80;
    localparam int         ROWS = 25;
    localparam logic [7:0] ATTR = 8'h07;
    localparam int         SCR  = COLS * ROWS * 2;
    localparam int LAT_PUT    = 3;
    localparam int LAT_SCROLL = 3 * (ROWS - 1) * COLS * 2 + COLS * 2 + 1;
    localparam int LAT_CLEAR  = SCR + 2;
    localparam int BOUND      = 20000;

    logic        clock = 1'b0;
    logic        rst;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic [12:0] mem_address;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic [7:0]  mem_q;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    always #5 clock = ~clock;

    cga_tty #(.COLS(COLS), .ROWS(ROWS), .ATTR(ATTR)) dut (
        .clock(clock), .rst(rst),
        .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
        .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    // video memory with one-cycle read latency plus a write log
    typedef struct { int addr; int data; int cyc; } wr_t;
    logic [7:0] vmem [0:8191];
    wr_t        wr_log[$];
    wr_t        wr_e;
    int         cyc = 0;
    int         wr_cnt = 0;
    logic       pre_en = 1'b0;
    int         pre_addr = 0;
    logic [7:0] pre_data = 8'h00;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        mem_q <= vmem[mem_address];
        if (mem_we) begin
            vmem[mem_address] <= mem_data;
            wr_cnt <= wr_cnt + 1;
            wr_e.addr = int'(mem_address);
            wr_e.data = int'(mem_data);
            wr_e.cyc  = cyc;
            wr_log.push_back(wr_e);
        end else if (pre_en) begin
            vmem[pre_addr] <= pre_data;
        end
    end

    // reference model: character grid plus cursor
    logic [7:0] chr [ROWS][COLS];
    int mx, my;

    task automatic m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                chr[r][c] = 8'h20;
        mx = 0;
        my = 0;
    endtask

    task automatic m_lf(output bit scrolled);
        scrolled = 1'b0;
        if (my < ROWS - 1) begin
            my++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    chr[r][c] = chr[r + 1][c];
            for (int c = 0; c < COLS; c++)
                chr[ROWS - 1][c] = 8'h20;
            mx = 0;
            scrolled = 1'b1;
        end
    endtask

    task automatic m_byte(input logic [7:0] b, output int lat);
        bit s;
        lat = 1;
        if (b >= 8'h20) begin
            chr[my][mx] = b;
            lat = LAT_PUT;
            if (mx < COLS - 1) begin
                mx++;
            end else begin
                mx = 0;
                m_lf(s);
                if (s) lat = LAT_PUT - 1 + LAT_SCROLL;
            end
        end else begin
            case (b)
                8'h0D: mx = 0;
                8'h0A: begin m_lf(s); if (s) lat = LAT_SCROLL; end
                8'h08: if (mx > 0) mx--;
                8'h0C: begin m_clear(); lat = LAT_CLEAR; end
`ifdef CGA_TTY_TAB_EN
                8'h09: begin
                    if ((mx / 8 + 1) * 8 >= COLS) begin
                        mx = 0;
                        m_lf(s);
                        if (s) lat = LAT_SCROLL;
                    end else begin
                        mx = (mx / 8 + 1) * 8;
                    end
                end
`endif
                default: ;
            endcase
        end
    endtask

    function automatic int screen_errs();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                if (vmem[(r * COLS + c) * 2] !== chr[r][c]) n++;
                if (vmem[(r * COLS + c) * 2 + 1] !== ATTR) n++;
            end
        return n;
    endfunction

    function automatic int clear_seq_errs();
        int n = 0;
        for (int k = 0; k < wr_log.size(); k++) begin
            if (wr_log[k].addr != k) n++;
            if (wr_log[k].data != ((k % 2 == 1) ? int'(ATTR) : 32'h20)) n++;
        end
        return n;
    endfunction

    // send one byte; lat = negedges from the accepting edge until ready is seen again
    task automatic send_byte(input logic [7:0] b, output int lat);
        int n = 0;
        while (char_ready !== 1'b1 && n < BOUND) begin @(negedge clock); n++; end
        if (char_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_wait_ready got=%b want=1", char_ready);
        end
        char_data  = b;
        char_valid = 1'b1;
        @(posedge clock);
        #1 char_valid = 1'b0;
        lat = 0;
        do begin @(negedge clock); lat++; end while (char_ready !== 1'b1 && lat < BOUND);
    endtask

    task automatic drive(input logic [7:0] b, output int exp_lat, output int lat);
        m_byte(b, exp_lat);
        send_byte(b, lat);
    endtask

    task automatic test_reset();
        int n = 0;
        rst = 1'b1;
        @(negedge clock); @(negedge clock);
        total++;
        if (mem_we !== 1'b0 || mem_address !== 13'd0 || mem_data !== 8'd0 || char_ready !== 1'b0 ||
            busy !== 1'b1 || cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
            bad++;
            $display("FAIL reset_values we=%b addr=%0d data=%h rdy=%b busy=%b x=%0d y=%0d want 0 0 00 0 1 0 0",
                     mem_we, mem_address, mem_data, char_ready, busy, cursor_x, cursor_y);
        end
        wr_log.delete();
        rst = 1'b0;
        while (char_ready !== 1'b1 && n < 5000) begin @(negedge clock); n++; end
        m_clear();
        total++;
        if (char_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_clear_done rdy=%b busy=%b want 1 0", char_ready, busy);
        end
        total++;
        if (wr_log.size() != SCR) begin
            bad++; $display("FAIL reset_clear_count got=%0d want=%0d", wr_log.size(), SCR);
        end
        total++;
        if (clear_seq_errs() != 0) begin
            bad++; $display("FAIL reset_clear_seq errors=%0d want=0", clear_seq_errs());
        end
        total++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
            bad++; $display("FAIL reset_cursor got=(%0d,%0d) want=(0,0)", cursor_x, cursor_y);
        end
        total++;
        if (screen_errs() != 0) begin
            bad++; $display("FAIL reset_screen errors=%0d want=0", screen_errs());
        end
    endtask

    task automatic test_single_char();
        int el, lat;
        wr_log.delete();
        drive(8'h41, el, lat);
        total++;
        if (wr_log.size() != 2) begin
            bad++; $display("FAIL char_writes got=%0d want=2", wr_log.size());
        end else begin
            total++;
            if (wr_log[0].addr != 0 || wr_log[0].data != 32'h41 || wr_log[1].addr != 1 ||
                wr_log[1].data != 32'h07 || wr_log[1].cyc != wr_log[0].cyc + 1) begin
                bad++;
                $display("FAIL char_pair got=%0d:%h %0d:%h dcyc=%0d want=0:41 1:07 dcyc=1",
                         wr_log[0].addr, wr_log[0].data, wr_log[1].addr, wr_log[1].data,
                         wr_log[1].cyc - wr_log[0].cyc);
            end
        end
        total++;
        if (lat != 3 || cursor_x !== 7'd1 || cursor_y !== 5'd0) begin
            bad++; $display("FAIL char_lat_cursor got lat=%0d x=%0d y=%0d want 3 1 0", lat, cursor_x, cursor_y);
        end
    endtask

    task automatic test_row_wrap();
        int el, lat;
        logic [7:0] last;
        drive(8'h0C, el, lat);
        for (int i = 0; i < 5; i++) drive(8'h0A, el, lat);
        wr_log.delete();
        last = 8'h20;
        for (int i = 0; i < COLS; i++) begin
            last = 8'($urandom_range(32, 255));
            drive(last, el, lat);
        end
        total++;
        if (wr_log.size() != 2 * COLS || wr_log[2 * COLS - 2].addr != 958 || wr_log[2 * COLS - 1].addr != 959 ||
            wr_log[2 * COLS - 2].data != int'(last) || wr_log[2 * COLS - 1].data != int'(ATTR)) begin
            bad++;
            $display("FAIL wrap_last_char writes=%0d want 160 ending 958:%h 959:07", wr_log.size(), last);
        end
        total++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd6) begin
            bad++; $display("FAIL wrap_cursor got=(%0d,%0d) want=(0,6)", cursor_x, cursor_y);
        end
        drive(8'h08, el, lat);
        total++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd6 || lat != 1) begin
            bad++; $display("FAIL bs_col0 got=(%0d,%0d) lat=%0d want=(0,6) lat=1", cursor_x, cursor_y, lat);
        end
        total++;
        if (screen_errs() != 0) begin
            bad++; $display("FAIL wrap_screen errors=%0d want=0", screen_errs());
        end
    endtask

    task automatic test_back_to_back();
        int el, n, base;
        base = (my * COLS + mx) * 2;
        wr_log.delete();
        m_byte(8'h42, el);
        m_byte(8'h43, el);
        char_data  = 8'h42;
        char_valid = 1'b1;
        @(posedge clock);
        #1 char_data = 8'h43;
        n = 0;
        @(negedge clock);
        while (char_ready !== 1'b1 && n < BOUND) begin @(negedge clock); n++; end
        @(posedge clock);
        #1 char_valid = 1'b0;
        n = 0;
        @(negedge clock);
        while (char_ready !== 1'b1 && n < BOUND) begin @(negedge clock); n++; end
        total++;
        if (wr_log.size() != 4) begin
            bad++; $display("FAIL b2b_writes got=%0d want=4", wr_log.size());
        end else begin
            total++;
            if (wr_log[0].addr != base || wr_log[0].data != 32'h42 || wr_log[2].addr != base + 2 ||
                wr_log[2].data != 32'h43 || wr_log[2].cyc - wr_log[0].cyc != 3) begin
                bad++;
                $display("FAIL b2b_order got=%0d:%h %0d:%h gap=%0d want=%0d:42 %0d:43 gap=3",
                         wr_log[0].addr, wr_log[0].data, wr_log[2].addr, wr_log[2].data,
                         wr_log[2].cyc - wr_log[0].cyc, base, base + 2);
            end
        end
        total++;
        if (cursor_x !== 7'(mx) || cursor_y !== 5'(my)) begin
            bad++; $display("FAIL b2b_cursor got=(%0d,%0d) want=(%0d,%0d)", cursor_x, cursor_y, mx, my);
        end
    endtask

    task automatic test_random();
        int el, lat, r;
        logic [7:0] b;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 255));
            else if (r < 78) b = 8'h0A;
            else if (r < 84) b = 8'h0D;
            else if (r < 90) b = 8'h08;
            else if (r < 94) b = 8'h09;
            else begin
                b = 8'($urandom_range(0, 31));
                if (b == 8'h0A || b == 8'h0D || b == 8'h08 || b == 8'h0C || b == 8'h09) b = 8'h1B;
            end
            drive(b, el, lat);
            total++;
            if (lat != el) begin
                bad++; $display("FAIL rnd_latency byte=%h got=%0d want=%0d", b, lat, el);
            end
            total++;
            if (cursor_x !== 7'(mx) || cursor_y !== 5'(my)) begin
                bad++; $display("FAIL rnd_cursor byte=%h got=(%0d,%0d) want=(%0d,%0d)", b, cursor_x, cursor_y, mx, my);
            end
        end
        total++;
        if (screen_errs() != 0) begin
            bad++; $display("FAIL rnd_screen errors=%0d want=0", screen_errs());
        end
    endtask

    task automatic test_tab();
        int el, lat;
        drive(8'h0D, el, lat);
        for (int i = 0; i < 3; i++) drive(8'h20, el, lat);
        wr_log.delete();
        drive(8'h09, el, lat);
        total++;
        if (cursor_x !== 7'(mx) || cursor_y !== 5'(my) || wr_log.size() != 0) begin
            bad++; $display("FAIL tab_from3 got=(%0d,%0d) writes=%0d want=(%0d,%0d) writes=0",
                            cursor_x, cursor_y, wr_log.size(), mx, my);
        end
        drive(8'h0D, el, lat);
        for (int i = 0; i < 75; i++) drive(8'h54, el, lat);
        drive(8'h09, el, lat);
        total++;
        if (cursor_x !== 7'(mx) || cursor_y !== 5'(my) || lat != el) begin
            bad++; $display("FAIL tab_from75 got=(%0d,%0d) lat=%0d want=(%0d,%0d) lat=%0d",
                            cursor_x, cursor_y, lat, mx, my, el);
        end
        total++;
        if (screen_errs() != 0) begin
            bad++; $display("FAIL tab_screen errors=%0d want=0", screen_errs());
        end
    endtask

    task automatic test_scroll();
        int el, lat, n;
        drive(8'h0C, el, lat);
        for (int i = 0; i < ROWS - 1; i++) drive(8'h0A, el, lat);
        for (int i = 0; i < 10; i++) drive(8'h51, el, lat);
        @(negedge clock);
        pre_addr = 160;
        pre_data = 8'h58;
        pre_en   = 1'b1;
        @(posedge clock);
        #1 pre_en = 1'b0;
        chr[1][0] = 8'h58;
        drive(8'h0A, el, lat);
        total++;
        if (lat != LAT_SCROLL) begin
            bad++; $display("FAIL scroll_latency got=%0d want=%0d", lat, LAT_SCROLL);
        end
        total++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd24) begin
            bad++; $display("FAIL scroll_cursor got=(%0d,%0d) want=(0,24)", cursor_x, cursor_y);
        end
        total++;
        if (vmem[0] !== 8'h58) begin
            bad++; $display("FAIL scroll_row1_to_row0 got=%h want=58", vmem[0]);
        end
        n = 0;
        for (int a = 3840; a < 4000; a++)
            if (vmem[a] !== ((a % 2 == 1) ? ATTR : 8'h20)) n++;
        total++;
        if (n != 0) begin
            bad++; $display("FAIL scroll_last_row errors=%0d want=0", n);
        end
        total++;
        if (screen_errs() != 0) begin
            bad++; $display("FAIL scroll_screen errors=%0d want=0", screen_errs());
        end
    endtask

    task automatic test_reset_mid_scroll();
        int n, base;
        n = 0;
        while (char_ready !== 1'b1 && n < BOUND) begin @(negedge clock); n++; end
        char_data  = 8'h0A;
        char_valid = 1'b1;
        @(posedge clock);
        #1 char_valid = 1'b0;
        base = wr_cnt;
        n = 0;
        while (wr_cnt - base < 100 && n < 1000) begin @(negedge clock); n++; end
        total++;
        if (wr_cnt - base != 100 || busy !== 1'b1) begin
            bad++; $display("FAIL midscroll_reach copies=%0d busy=%b want 100 1", wr_cnt - base, busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if (mem_we !== 1'b0 || mem_address !== 13'd0 || mem_data !== 8'd0 || char_ready !== 1'b0 ||
            busy !== 1'b1 || cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
            bad++;
            $display("FAIL midscroll_reset we=%b addr=%0d data=%h rdy=%b busy=%b x=%0d y=%0d want 0 0 00 0 1 0 0",
                     mem_we, mem_address, mem_data, char_ready, busy, cursor_x, cursor_y);
        end
        wr_log.delete();
        @(negedge clock);
        rst = 1'b0;
        n = 0;
        while (char_ready !== 1'b1 && n < 5000) begin @(negedge clock); n++; end
        m_clear();
        total++;
        if (wr_log.size() != SCR || clear_seq_errs() != 0) begin
            bad++; $display("FAIL midscroll_clear writes=%0d seqerr=%0d want=%0d 0", wr_log.size(), clear_seq_errs(), SCR);
        end
        total++;
        if (char_ready !== 1'b1 || cursor_x !== 7'd0 || cursor_y !== 5'd0 || screen_errs() != 0) begin
            bad++; $display("FAIL midscroll_after rdy=%b x=%0d y=%0d screenerr=%0d want 1 0 0 0",
                            char_ready, cursor_x, cursor_y, screen_errs());
        end
    endtask

    initial begin
        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        test_reset();
        test_single_char();
        test_row_wrap();
        test_back_to_back();
        test_random();
        test_tab();
        test_scroll();
        test_reset_mid_scroll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
